iicmb_wb_sequencer: RTL and testbench



---
 rtl/iicmb_wb_sequencer_if.sv | 26 ++
 rtl/iicmb_wb_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_iicmb_wb_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iicmb_wb_sequencer_if.sv
// rtl/iicmb_wb_sequencer_if.sv - Wishbone master port plus controller irq for the iicmb sequencer
//   master modport: drives cyc_o/stb_o/we_o/adr_o/dat_o, samples dat_i/ack_i/irq_i
//   slave  modport: the iicmb_m_wb register side
interface iicmb_wb_sequencer_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
);
    logic              cyc_o;
    logic              stb_o;
    logic              we_o;
    logic [ADDR_W-1:0] adr_o;
    logic [DATA_W-1:0] dat_o;
    logic [DATA_W-1:0] dat_i;
    logic              ack_i;
    logic              irq_i;

    modport master (
        output cyc_o, stb_o, we_o, adr_o, dat_o,
        input  dat_i, ack_i, irq_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, adr_o, dat_o,
        output dat_i, ack_i, irq_i
    );
endinterface

// File: rtl/iicmb_wb_sequencer.sv
// rtl/iicmb_wb_sequencer.sv - turns one I2C transaction request into iicmb_m_wb register traffic
//   clk_i, rst_i (async, active-low)
//   req_*            : transaction request (bus, address, direction, length), req_ready high in IDLE
//   wdata*/rdata*    : write byte stream in, read byte stream out
//   done_valid/status: one pulse per request, 0=OK 1=NAK 2=ARB_LOST 3=ERR 4=TIMEOUT
//   wb               : Wishbone master + irq (iicmb_wb_sequencer_if.master)
//   Optional macro IICMB_SEQ_TIMEOUT_EN: irq watchdog of TIMEOUT_CYCLES that disables the core.
module iicmb_wb_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int MAX_LEN        = 32,
    parameter int LEN_W          = $clog2(MAX_LEN + 1),
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [7:0]                req_bus_id,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr,
    input  logic                      req_rw,
    input  logic [LEN_W-1:0]          req_len,
    input  logic [7:0]                wdata,
    input  logic                      wdata_valid,
    output logic                      wdata_ready,
    output logic [7:0]                rdata,
    output logic                      rdata_valid,
    input  logic                      rdata_ready,
    output logic                      done_valid,
    output logic [2:0]                done_status,
    iicmb_wb_sequencer_if.master      wb
);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);

    localparam logic [2:0] ST_OK = 3'd0, ST_NAK = 3'd1, ST_AL = 3'd2, ST_ERR = 3'd3, ST_TMO = 3'd4;

    typedef enum logic [4:0] {
        S_IDLE, S_ENABLE, S_ENABLED, S_SETBUS, S_SETBUS_CMD, S_START, S_ADDR_CMD,
        S_WR_WAIT, S_WR_CMD, S_RD_CMD, S_RD_PRESENT, S_RD_HOLD, S_STOP,
        S_WAIT_IRQ, S_IRQ_EVAL, S_WB, S_TIMEOUT, S_FINISH
    } state_t;

    typedef enum logic [2:0] {
        PH_SETBUS, PH_START, PH_ADDR, PH_WR, PH_RD, PH_STOP
    } phase_t;

    state_t                    state, ret_state;
    phase_t                    phase;
    logic                      enabled;
    logic [7:0]                cur_bus, bus_l;
    logic [I2C_ADDR_WIDTH-1:0] addr_l;
    logic                      rw_l;
    logic [LEN_W-1:0]          len_l, cnt;
    logic [2:0]                status;
    logic [WB_DATA_WIDTH-1:0]  rd_buf;
    logic                      last_byte;

    assign last_byte = (cnt == len_l - LEN_W'(1));

`ifdef IICMB_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Launch one Wishbone access; S_WB holds it until ack, then resumes at ret.
    task automatic wb_issue(input logic we, input logic [WB_ADDR_WIDTH-1:0] adr,
                            input logic [WB_DATA_WIDTH-1:0] dat, input state_t ret);
        wb.cyc_o  <= 1'b1;
        wb.stb_o  <= 1'b1;
        wb.we_o   <= we;
        wb.adr_o  <= adr;
        wb.dat_o  <= dat;
        ret_state <= ret;
        state     <= S_WB;
    endtask

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            ret_state   <= S_IDLE;
            phase       <= PH_SETBUS;
            enabled     <= 1'b0;
            cur_bus     <= 8'd0;
            bus_l       <= 8'd0;
            addr_l      <= '0;
            rw_l        <= 1'b0;
            len_l       <= '0;
            cnt         <= '0;
            status      <= ST_OK;
            rd_buf      <= '0;
            req_ready   <= 1'b1;
            wdata_ready <= 1'b0;
            rdata       <= 8'd0;
            rdata_valid <= 1'b0;
            done_valid  <= 1'b0;
            done_status <= ST_OK;
            wb.cyc_o    <= 1'b0;
            wb.stb_o    <= 1'b0;
            wb.we_o     <= 1'b0;
            wb.adr_o    <= '0;
            wb.dat_o    <= '0;
`ifdef IICMB_SEQ_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done_valid <= 1'b0;
                    if (req_valid && req_ready) begin
                        bus_l  <= req_bus_id;
                        addr_l <= req_addr;
                        rw_l   <= req_rw;
                        len_l  <= req_len;
                        status <= ST_OK;
                        if (req_len > LEN_W'(MAX_LEN)) begin
                            // Rejected without touching the bus; ready stays up.
                            done_valid  <= 1'b1;
                            done_status <= ST_ERR;
                        end else begin
                            req_ready <= 1'b0;
                            if (!enabled)                   state <= S_ENABLE;
                            else if (req_bus_id != cur_bus) state <= S_SETBUS;
                            else                            state <= S_START;
                        end
                    end
                end
                S_ENABLE:     wb_issue(1'b1, A_CSR, WB_DATA_WIDTH'(8'hC0), S_ENABLED);
                S_ENABLED: begin
                    enabled <= 1'b1;
                    state   <= S_SETBUS;
                end
                S_SETBUS:     wb_issue(1'b1, A_DPR, WB_DATA_WIDTH'(bus_l), S_SETBUS_CMD);
                S_SETBUS_CMD: begin
                    phase <= PH_SETBUS;
                    wb_issue(1'b1, A_CMDR, WB_DATA_WIDTH'(8'h06), S_WAIT_IRQ);
                end
                S_START: begin
                    phase <= PH_START;
                    wb_issue(1'b1, A_CMDR, WB_DATA_WIDTH'(8'h04), S_WAIT_IRQ);
                end
                S_ADDR_CMD: begin
                    phase <= PH_ADDR;
                    wb_issue(1'b1, A_CMDR, WB_DATA_WIDTH'(8'h01), S_WAIT_IRQ);
                end
                S_WR_WAIT: begin
                    // Ready rises only after valid is seen, and drops on the handshake.
                    if (wdata_ready && wdata_valid) begin
                        wdata_ready <= 1'b0;
                        wb_issue(1'b1, A_DPR, WB_DATA_WIDTH'(wdata), S_WR_CMD);
                    end else if (wdata_valid) begin
                        wdata_ready <= 1'b1;
                    end
                end
                S_WR_CMD: begin
                    phase <= PH_WR;
                    wb_issue(1'b1, A_CMDR, WB_DATA_WIDTH'(8'h01), S_WAIT_IRQ);
                end
                S_RD_CMD: begin
                    phase <= PH_RD;
                    wb_issue(1'b1, A_CMDR, last_byte ? WB_DATA_WIDTH'(8'h03) : WB_DATA_WIDTH'(8'h02),
                             S_WAIT_IRQ);
                end
                S_RD_PRESENT: begin
                    rdata       <= rd_buf[7:0];
                    rdata_valid <= 1'b1;
                    state       <= S_RD_HOLD;
                end
                S_RD_HOLD: begin
                    if (rdata_ready) begin
                        rdata_valid <= 1'b0;
                        cnt         <= cnt + LEN_W'(1);
                        state       <= last_byte ? S_STOP : S_RD_CMD;
                    end
                end
                S_STOP: begin
                    phase <= PH_STOP;
                    wb_issue(1'b1, A_CMDR, WB_DATA_WIDTH'(8'h05), S_WAIT_IRQ);
                end
                S_WAIT_IRQ: begin
`ifdef IICMB_SEQ_TIMEOUT_EN
                    if (wb.irq_i) begin
                        tmo_cnt <= '0;
                        wb_issue(1'b0, A_CMDR, '0, S_IRQ_EVAL);
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        tmo_cnt <= '0;
                        wb_issue(1'b1, A_CSR, '0, S_TIMEOUT);
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`else
                    if (wb.irq_i) wb_issue(1'b0, A_CMDR, '0, S_IRQ_EVAL);
`endif
                end
                S_IRQ_EVAL: begin
                    // CMDR status bits: 7=DON 6=NAK 5=AL 4=ERR, worst first.
                    if (rd_buf[4]) begin
                        status  <= ST_ERR;
                        enabled <= 1'b0;
                        state   <= S_FINISH;
                    end else if (rd_buf[5]) begin
                        status <= ST_AL;
                        state  <= S_FINISH;
                    end else if (rd_buf[6]) begin
                        status <= ST_NAK;
                        state  <= (phase == PH_STOP) ? S_FINISH : S_STOP;
                    end else if (rd_buf[7]) begin
                        case (phase)
                            PH_SETBUS: begin
                                cur_bus <= bus_l;
                                state   <= S_START;
                            end
                            PH_START: wb_issue(1'b1, A_DPR, WB_DATA_WIDTH'({addr_l, rw_l}), S_ADDR_CMD);
                            PH_ADDR: begin
                                cnt <= '0;
                                if (len_l == '0) state <= S_STOP;
                                else if (rw_l)   state <= S_RD_CMD;
                                else             state <= S_WR_WAIT;
                            end
                            PH_WR: begin
                                cnt   <= cnt + LEN_W'(1);
                                state <= last_byte ? S_STOP : S_WR_WAIT;
                            end
                            PH_RD:   wb_issue(1'b0, A_DPR, '0, S_RD_PRESENT);
                            default: state <= S_FINISH;
                        endcase
                    end else begin
                        // No status bit at all: treat the core as broken.
                        status  <= ST_ERR;
                        enabled <= 1'b0;
                        state   <= S_FINISH;
                    end
                end
                S_WB: begin
                    if (wb.ack_i) begin
                        wb.cyc_o <= 1'b0;
                        wb.stb_o <= 1'b0;
                        wb.we_o  <= 1'b0;
                        wb.adr_o <= '0;
                        wb.dat_o <= '0;
                        rd_buf   <= wb.dat_i;
                        state    <= ret_state;
                    end
                end
`ifdef IICMB_SEQ_TIMEOUT_EN
                S_TIMEOUT: begin
                    enabled <= 1'b0;
                    status  <= ST_TMO;
                    state   <= S_FINISH;
                end
`endif
                S_FINISH: begin
                    done_valid  <= 1'b1;
                    done_status <= status;
                    req_ready   <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iicmb_wb_sequencer.sv
// tb/tb_iicmb_wb_sequencer.sv - scoreboard bench for iicmb_wb_sequencer with an iicmb_m_wb register model
module tb_iicmb_wb_sequencer;
    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_bus_id = 8'd0;
    logic [6:0] req_addr = 7'd0;
    logic       req_rw = 1'b0;
    logic [5:0] req_len = 6'd0;
    logic [7:0] wdata = 8'd0;
    logic       wdata_valid = 1'b0;
    logic       wdata_ready;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       rdata_ready = 1'b1;
    logic       done_valid;
    logic [2:0] done_status;

    iicmb_wb_sequencer_if #(.ADDR_W(2), .DATA_W(8)) wb_bus ();

    iicmb_wb_sequencer #(
        .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .I2C_ADDR_WIDTH(7),
        .MAX_LEN(32), .LEN_W(6), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_bus_id(req_bus_id),
        .req_addr(req_addr), .req_rw(req_rw), .req_len(req_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
        .done_valid(done_valid), .done_status(done_status),
        .wb(wb_bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    logic [9:0] exp_wb[$];   // {adr, dat} of every expected register write
    logic [7:0] exp_rd[$];
    logic [2:0] exp_done[$];
    logic [7:0] wq[$];       // write bytes offered on the wdata stream
    logic [7:0] rd_q[$];     // bytes the slave returns for read commands
    int done_cnt = 0;
    int wdata_hs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- register-side model ----------------
    logic [7:0] dpr_w = 8'd0, dpr_r = 8'd0, cmd_stat = 8'd0;
    int  irq_cnt = 0;
    int  wb_wait = 0;
    bit  after_start = 0, irq_stuck = 0, al_next = 0, nak_en = 0;
    logic [6:0] nak_addr = 7'd0;

    task automatic model_access();
        if (wb_bus.we_o) begin
            if (wb_bus.adr_o == 2'd1) dpr_w = wb_bus.dat_o;
            if (wb_bus.adr_o == 2'd2) begin
                cmd_stat = 8'h80;
                case (wb_bus.dat_o[2:0])
                    3'b100: begin
                        after_start = !al_next;
                        if (al_next) begin cmd_stat = 8'h20; al_next = 0; end
                    end
                    3'b001: begin
                        if (after_start && nak_en && dpr_w[7:1] == nak_addr) cmd_stat = 8'h40;
                        after_start = 0;
                    end
                    3'b010, 3'b011: dpr_r = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hEE;
                    default: ;
                endcase
                if (!irq_stuck) irq_cnt = 3;
            end
            wb_bus.dat_i = 8'd0;
        end else begin
            case (wb_bus.adr_o)
                2'd1: wb_bus.dat_i = dpr_r;
                2'd2: begin wb_bus.dat_i = cmd_stat; wb_bus.irq_i = 1'b0; end
                default: wb_bus.dat_i = 8'd0;
            endcase
        end
    endtask

    initial begin
        wb_bus.ack_i = 1'b0;
        wb_bus.irq_i = 1'b0;
        wb_bus.dat_i = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (irq_cnt > 0) begin
                irq_cnt--;
                if (irq_cnt == 0) wb_bus.irq_i = 1'b1;
            end
            if (wb_bus.ack_i) wb_bus.ack_i = 1'b0;
            else if (wb_bus.cyc_o && wb_bus.stb_o) begin
                if (wb_wait == 0) wb_wait = 1;
                else begin
                    wb_wait = 0;
                    model_access();
                    wb_bus.ack_i = 1'b1;
                end
            end
        end
    end

    // ---------------- write-byte source ----------------
    initial begin
        bit hs;
        forever begin
            @(negedge clk);
            hs = wdata_valid && wdata_ready;
            @(posedge clk); #1;
            if (hs) begin
                wdata_hs++;
                if (wq.size() != 0) void'(wq.pop_front());
            end
            wdata_valid = (wq.size() != 0);
            if (wq.size() != 0) wdata = wq[0];
        end
    end

    // ---------------- monitors ----------------
    logic [7:0] prev_rdata = 8'd0;
    bit         prev_pending = 0;

    always @(negedge clk) begin
        if (wb_bus.cyc_o && wb_bus.stb_o && wb_bus.we_o && wb_bus.ack_i) begin
            if (exp_wb.size() == 0) begin
                total++;
                $display("FAIL wb_write: got adr %0d dat 0x%0h, expected no write",
                         wb_bus.adr_o, wb_bus.dat_o);
            end else check("wb_write", {wb_bus.adr_o, wb_bus.dat_o}, exp_wb.pop_front());
        end
        if (prev_pending) begin
            check("rdata_valid_hold", rdata_valid, 1'b1);
            check("rdata_hold", rdata, prev_rdata);
        end
        prev_pending = rdata_valid && !rdata_ready;
        prev_rdata   = rdata;
        if (rdata_valid && rdata_ready) begin
            if (exp_rd.size() == 0) begin
                total++;
                $display("FAIL rdata: got 0x%0h, expected no read byte", rdata);
            end else check("rdata", rdata, exp_rd.pop_front());
        end
        if (done_valid) begin
            done_cnt++;
            if (exp_done.size() == 0) begin
                total++;
                $display("FAIL done_status: got %0d, expected no done", done_status);
            end else check("done_status", done_status, exp_done.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    bit         tb_en = 0;
    logic [7:0] tb_bus = 8'd0;

    task automatic push_wb(input logic [1:0] adr, input logic [7:0] dat);
        exp_wb.push_back({adr, dat});
    endtask

    task automatic issue_req(input logic [7:0] bus, input logic [6:0] addr, input logic rw,
                             input int len);
        bit got = 0;
        req_bus_id = bus; req_addr = addr; req_rw = rw; req_len = 6'(len);
        req_valid  = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (req_ready) begin got = 1; break; end
        end
        if (!got) begin total++; $display("FAIL req_ready: got 0, expected 1 within bound"); end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        bit got = 0;
        for (int k = 0; k < 20000; k++) begin
            if (done_cnt != d0) begin got = 1; break; end
            @(posedge clk);
        end
        if (!got) begin total++; $display("FAIL done_timeout: got no done, expected done pulse"); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_req(input logic [7:0] bus, input logic [6:0] addr, input logic rw,
                           input int len, input int first, input bit nak, input bit bp);
        int  d0  = done_cnt;
        int  hs0 = wdata_hs;
        bit  sb  = 0;
        if (!tb_en) begin push_wb(2'd0, 8'hC0); tb_en = 1; sb = 1; end
        if (sb || bus != tb_bus) begin push_wb(2'd1, bus); push_wb(2'd2, 8'h06); tb_bus = bus; end
        push_wb(2'd2, 8'h04);
        push_wb(2'd1, {addr, rw});
        push_wb(2'd2, 8'h01);
        if (nak) begin
            nak_en = 1; nak_addr = addr;
            for (int i = 0; i < len; i++) wq.push_back(8'(first + i));
            push_wb(2'd2, 8'h05);
            exp_done.push_back(3'd1);
        end else begin
            for (int i = 0; i < len; i++) begin
                if (!rw) begin
                    push_wb(2'd1, 8'(first + i));
                    push_wb(2'd2, 8'h01);
                    wq.push_back(8'(first + i));
                end else begin
                    push_wb(2'd2, (i == len - 1) ? 8'h03 : 8'h02);
                    rd_q.push_back(8'(first + i));
                    exp_rd.push_back(8'(first + i));
                end
            end
            push_wb(2'd2, 8'h05);
            exp_done.push_back(3'd0);
        end
        if (bp) begin
            rdata_ready = 1'b0;
            fork
                begin
                    for (int k = 0; k < 5000; k++) begin
                        @(posedge clk);
                        if (rdata_valid) break;
                    end
                    repeat (10) @(posedge clk);
                    #1 rdata_ready = 1'b1;
                end
            join_none
        end
        issue_req(bus, addr, rw, len);
        wait_done(d0);
        rdata_ready = 1'b1;
        if (nak) begin
            check("wdata_hs_after_nak", wdata_hs - hs0, 0);
            wq.delete();
            nak_en = 0;
        end else if (!rw) check("wdata_hs", wdata_hs - hs0, len);
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_cyc", {wb_bus.cyc_o, wb_bus.stb_o, wb_bus.we_o}, 3'b000);
        check("reset_stream", {wdata_ready, rdata_valid, done_valid, done_status}, 6'd0);
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_req(8'd5, 7'h22, 1'b0, 32, 0, 0, 0);
        run_req(8'd5, 7'h22, 1'b1, 32, 100, 0, 0);
        for (int i = 0; i < 64; i++) begin
            if (i % 2 == 0) run_req(8'd5, 7'h22, 1'b0, 1, 64 + i, 0, 0);
            else            run_req(8'd5, 7'h22, 1'b1, 1, 63 - i, 0, 0);
        end
        run_req(8'd5, 7'h30, 1'b0, 4, 9, 1, 0);
        run_req(8'd2, 7'h22, 1'b1, 3, 200, 0, 1);
        run_req(8'd2, 7'h50, 1'b0, 0, 0, 0, 0);

        // Oversized length: error pulse, no bus traffic.
        d0 = done_cnt;
        exp_done.push_back(3'd3);
        issue_req(8'd2, 7'h22, 1'b0, 33);
        wait_done(d0);

        // Arbitration lost on START: no STOP.
        d0 = done_cnt;
        al_next = 1;
        push_wb(2'd2, 8'h04);
        exp_done.push_back(3'd2);
        issue_req(8'd2, 7'h22, 1'b1, 1);
        wait_done(d0);

`ifdef IICMB_SEQ_TIMEOUT_EN
        d0 = done_cnt;
        irq_stuck = 1;
        push_wb(2'd2, 8'h04);
        push_wb(2'd0, 8'h00);
        exp_done.push_back(3'd4);
        issue_req(8'd2, 7'h22, 1'b1, 1);
        wait_done(d0);
        irq_stuck = 0;
        tb_en = 0;
        run_req(8'd2, 7'h22, 1'b1, 1, 7, 0, 0);
`endif

        check("wb_queue_drained", exp_wb.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
        check("done_queue_drained", exp_done.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
